// File: rtl/ir_fetch_queue_pkg.sv
// ir_fetch_queue_pkg
//   Shared constants and types for the instruction fetch queue.
//   LINE_BYTES    : bytes per fetched code line
//   BUF_BYTES     : capacity of the instruction byte ring
//   DEF_RESET_EIP : default EIP after reset
//   DEF_RESET_CS  : default CS after reset
//   fetch_state_e : fetch sequencer states
package ir_fetch_queue_pkg;

    localparam int          LINE_BYTES    = 16;
    localparam int          BUF_BYTES     = 32;
    localparam logic [31:0] DEF_RESET_EIP = 32'h0000_FFF0;
    localparam logic [15:0] DEF_RESET_CS  = 16'hF000;

    typedef enum logic {
        F_IDLE,
        F_REQ
    } fetch_state_e;

endpackage

// File: rtl/ir_byte_ring.sv
// ir_byte_ring
//   32 x 8 instruction byte storage.
//   Write port: bytes wr_skip..15 of wr_data land at consecutive ring slots
//   starting at wr_base (modulo 32). Read port: 16 consecutive bytes starting
//   at rd_head, first byte in rd_window[127:120].
//   clk, reset  : clock, synchronous active-high clear of all bytes
//   wr_en       : append a line this cycle
//   wr_base     : ring slot receiving the first kept byte
//   wr_skip     : number of leading line bytes to drop
//   wr_data     : line bytes, byte k in wr_data[8k+7:8k]
//   rd_head     : ring slot of window byte 0
//   rd_window   : 16-byte window
module ir_byte_ring
    import ir_fetch_queue_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [4:0]   wr_base,
    input  logic [3:0]   wr_skip,
    input  logic [127:0] wr_data,
    input  logic [4:0]   rd_head,
    output logic [127:0] rd_window
);

    logic [7:0] mem_q [BUF_BYTES];
    logic [7:0] mem_d [BUF_BYTES];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
                if (4'(k) >= wr_skip) begin
                    // kept byte k goes (k - skip) slots past the append base
                    mem_d[wr_base + 5'(k) - {1'b0, wr_skip}] = wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_window = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            rd_window[127 - 8*i -: 8] = mem_q[rd_head + 5'(i)];
        end
    end

endmodule

// File: rtl/ir_fetch_queue.sv
// ir_fetch_queue
//   Fetch sequencer and instruction byte queue feeding decode. Requests
//   16-byte code lines, keeps up to 32 bytes in a ring, presents a 16-byte
//   window at EIP and advances by the decoded instruction length. A redirect
//   flushes the queue and restarts fetch at the new EIP.
//   clk, reset              : clock, synchronous active-high reset
//   fetch_req/addr/ack/data : line fetch handshake (one request outstanding)
//   ir_valid, IR            : 16-byte window valid / window bytes
//   EIP_OUT, CS_OUT         : address of window byte 0, code segment
//   dec_ready, instr_length : decode consumes instr_length bytes
//   redirect, redirect_eip, redirect_cs : flush and restart
module ir_fetch_queue
    import ir_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_EIP = DEF_RESET_EIP,
    parameter logic [15:0] RESET_CS  = DEF_RESET_CS
) (
    input  logic         clk,
    input  logic         reset,
    output logic         fetch_req,
    output logic [31:0]  fetch_addr,
    input  logic         fetch_ack,
    input  logic [127:0] fetch_data,
    output logic         ir_valid,
    output logic [127:0] IR,
    output logic [31:0]  EIP_OUT,
    output logic [15:0]  CS_OUT,
    input  logic         dec_ready,
    input  logic [3:0]   instr_length,
    input  logic         redirect,
    input  logic [31:0]  redirect_eip,
    input  logic [15:0]  redirect_cs
);

    fetch_state_e state_q, state_d;
    logic [4:0]   head_q, head_d;
    logic [5:0]   count_q, count_d;
    logic [31:0]  eip_q, eip_d;
    logic [15:0]  cs_q, cs_d;
    logic [27:0]  faddr_q, faddr_d;
    logic [3:0]   skip_q, skip_d;

    logic         consume;
    logic         append;
    logic         wr_en;
    logic [4:0]   wr_base;
    logic [5:0]   use_bytes;
    logic [5:0]   app_bytes;

    assign ir_valid   = (count_q >= 6'(LINE_BYTES)) && !reset;
    assign fetch_req  = (state_q == F_REQ);
    assign fetch_addr = fetch_req ? {faddr_q, 4'b0000} : 32'h0;
    assign EIP_OUT    = eip_q;
    assign CS_OUT     = cs_q;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        count_d   = count_q;
        eip_d     = eip_q;
        cs_d      = cs_q;
        faddr_d   = faddr_q;
        skip_d    = skip_q;

        consume   = ir_valid && dec_ready;
        append    = (state_q == F_REQ) && fetch_ack;
        use_bytes = consume ? {2'b00, instr_length} : 6'd0;
        app_bytes = append ? (6'(LINE_BYTES) - {2'b00, skip_q}) : 6'd0;
        // append lands after the bytes already held, relative to the old head
        wr_base   = head_q + count_q[4:0];
        wr_en     = append && !redirect;

        case (state_q)
            F_IDLE: begin
                if (count_q <= 6'(LINE_BYTES)) begin
                    state_d = F_REQ;
                end
            end
            F_REQ: begin
                if (fetch_ack) begin
                    state_d = F_IDLE;
                    faddr_d = faddr_q + 28'd1;
                    skip_d  = 4'd0;
                end
            end
        endcase

        count_d = count_q - use_bytes + app_bytes;
        head_d  = head_q + use_bytes[4:0];
        eip_d   = eip_q + 32'(use_bytes);

        if (redirect) begin
            state_d = F_REQ;
            head_d  = 5'd0;
            count_d = 6'd0;
            eip_d   = redirect_eip;
            cs_d    = redirect_cs;
            faddr_d = redirect_eip[31:4];
            skip_d  = redirect_eip[3:0];
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= F_IDLE;
            head_q  <= 5'd0;
            count_q <= 6'd0;
            eip_q   <= RESET_EIP;
            cs_q    <= RESET_CS;
            faddr_q <= RESET_EIP[31:4];
            skip_q  <= RESET_EIP[3:0];
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            count_q <= count_d;
            eip_q   <= eip_d;
            cs_q    <= cs_d;
            faddr_q <= faddr_d;
            skip_q  <= skip_d;
        end
    end

    ir_byte_ring u_ring (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_base   (wr_base),
        .wr_skip   (skip_q),
        .wr_data   (fetch_data),
        .rd_head   (head_q),
        .rd_window (IR)
    );

endmodule

// File: tb/tb_ir_fetch_queue.sv
module tb_ir_fetch_queue;

    logic         clk = 1'b0;
    logic         reset;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         fetch_ack;
    logic [127:0] fetch_data;
    logic         ir_valid;
    logic [127:0] IR;
    logic [31:0]  EIP_OUT;
    logic [15:0]  CS_OUT;
    logic         dec_ready;
    logic [3:0]   instr_length;
    logic         redirect;
    logic [31:0]  redirect_eip;
    logic [15:0]  redirect_cs;

    int total = 0;
    int bad   = 0;

    // reference model: byte queue of the architectural instruction stream
    logic [7:0]  q[$];
    logic [31:0] m_eip;
    logic [15:0] m_cs;
    logic [27:0] m_faddr;
    logic [3:0]  m_skip;

    ir_fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ack    (fetch_ack),
        .fetch_data   (fetch_data),
        .ir_valid     (ir_valid),
        .IR           (IR),
        .EIP_OUT      (EIP_OUT),
        .CS_OUT       (CS_OUT),
        .dec_ready    (dec_ready),
        .instr_length (instr_length),
        .redirect     (redirect),
        .redirect_eip (redirect_eip),
        .redirect_cs  (redirect_cs)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24];
    endfunction

    function automatic logic [127:0] line(input logic [27:0] fa);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) d[8*k +: 8] = mem({fa, 4'(k)});
        return d;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic [127:0] w;
        chk("ir_valid", {127'b0, ir_valid}, {127'b0, q.size() >= 16});
        if (q.size() >= 16) begin
            for (int i = 0; i < 16; i++) w[127 - 8*i -: 8] = q[i];
            chk("ir_window", IR, w);
        end
        chk("eip", {96'b0, EIP_OUT}, {96'b0, m_eip});
        chk("cs", {112'b0, CS_OUT}, {112'b0, m_cs});
        if (fetch_req) chk("fetch_addr", {96'b0, fetch_addr}, {96'b0, m_faddr, 4'b0});
        if (q.size() > 16) chk("no_req_when_full", {127'b0, fetch_req}, 128'b0);
    endtask

    task automatic step(input bit ack, input bit rdy, input logic [3:0] len,
                        input bit redir, input logic [31:0] reip, input logic [15:0] rcs);
        bit ack_drv;
        ack_drv      = ack && fetch_req;
        fetch_ack    = ack_drv;
        fetch_data   = line(m_faddr);
        dec_ready    = rdy;
        instr_length = len;
        redirect     = redir;
        redirect_eip = reip;
        redirect_cs  = rcs;
        @(posedge clk);
        if (redir) begin
            q.delete();
            m_eip   = reip;
            m_cs    = rcs;
            m_faddr = reip[31:4];
            m_skip  = reip[3:0];
        end else begin
            if (q.size() >= 16 && rdy) begin
                for (int i = 0; i < int'(len); i++) void'(q.pop_front());
                m_eip = m_eip + 32'(len);
            end
            if (ack_drv) begin
                for (int k = int'(m_skip); k < 16; k++) q.push_back(mem({m_faddr, 4'(k)}));
                m_faddr = m_faddr + 28'd1;
                m_skip  = 4'd0;
            end
        end
        #1;
        fetch_ack = 1'b0;
        redirect  = 1'b0;
        dec_ready = 1'b0;
        model_check();
    endtask

    task automatic wait_req(input bit rdy);
        int n = 0;
        while (!fetch_req && n < 20) begin
            step(0, rdy, 4'd0, 0, 32'h0, 16'h0);
            n++;
        end
        chk("req_timeout", {127'b0, fetch_req}, 128'b1);
    endtask

    initial begin
        int n_cons;
        int cyc;
        bit a, r;
        logic [3:0] l;

        reset = 1'b1; fetch_ack = 1'b0; fetch_data = '0; dec_ready = 1'b0;
        instr_length = 4'd0; redirect = 1'b0; redirect_eip = '0; redirect_cs = '0;
        repeat (2) @(posedge clk);
        #1;
        q.delete(); m_eip = 32'h0000_FFF0; m_cs = 16'hF000; m_faddr = 28'hFFF; m_skip = 4'h0;
        chk("rst_fetch_req", {127'b0, fetch_req}, 128'b0);
        chk("rst_fetch_addr", {96'b0, fetch_addr}, 128'b0);
        chk("rst_ir_valid", {127'b0, ir_valid}, 128'b0);
        chk("rst_ir", IR, 128'b0);
        chk("rst_eip", {96'b0, EIP_OUT}, {96'b0, 32'h0000_FFF0});
        chk("rst_cs", {112'b0, CS_OUT}, {112'b0, 16'hF000});
        reset = 1'b0;

        // first cycle out of reset idles, second requests the reset line
        chk("idle_after_reset", {127'b0, fetch_req}, 128'b0);
        step(0, 0, 4'd0, 0, 32'h0, 16'h0);
        chk("req_after_reset", {127'b0, fetch_req}, 128'b1);
        chk("reset_line_addr", {96'b0, fetch_addr}, {96'b0, 32'h0000_FFF0});
        step(1, 0, 4'd0, 0, 32'h0, 16'h0);
        chk("reset_ir_valid", {127'b0, ir_valid}, 128'b1);
        chk("reset_ir_byte0", {120'b0, IR[127:120]}, {120'b0, mem(32'h0000_FFF0)});
        step(0, 1, 4'd0, 0, 32'h0, 16'h0);
        chk("len0_eip", {96'b0, EIP_OUT}, {96'b0, 32'h0000_FFF0});
        step(0, 1, 4'd3, 0, 32'h0, 16'h0);
        chk("len3_eip", {96'b0, EIP_OUT}, {96'b0, 32'h0000_FFF3});

        // unaligned redirect needs two lines before the window is valid
        step(0, 0, 4'd0, 1, 32'h0000_1003, 16'h0010);
        chk("redir_req", {127'b0, fetch_req}, 128'b1);
        chk("redir_addr", {96'b0, fetch_addr}, {96'b0, 32'h0000_1000});
        step(1, 0, 4'd0, 0, 32'h0, 16'h0);
        chk("skip_first_invalid", {127'b0, ir_valid}, 128'b0);
        wait_req(0);
        chk("second_line_addr", {96'b0, fetch_addr}, {96'b0, 32'h0000_1010});
        step(1, 0, 4'd0, 0, 32'h0, 16'h0);
        chk("skip_valid", {127'b0, ir_valid}, 128'b1);
        chk("skip_byte0", {120'b0, IR[127:120]}, {120'b0, mem(32'h0000_1003)});

        // consume and append in the same cycle
        step(0, 0, 4'd0, 1, 32'h0000_2000, 16'h0020);
        step(1, 0, 4'd0, 0, 32'h0, 16'h0);
        wait_req(0);
        step(1, 1, 4'd5, 0, 32'h0, 16'h0);
        chk("cons_app_eip", {96'b0, EIP_OUT}, {96'b0, 32'h0000_2005});
        chk("cons_app_size", 128'(q.size()), 128'd27);

        // fill to 32 and stall
        step(0, 0, 4'd0, 1, 32'h0000_3000, 16'h0030);
        step(1, 0, 4'd0, 0, 32'h0, 16'h0);
        wait_req(0);
        step(1, 0, 4'd0, 0, 32'h0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 4'd7, 0, 32'h0, 16'h0);
            chk("stall_no_req", {127'b0, fetch_req}, 128'b0);
        end
        chk("stall_eip", {96'b0, EIP_OUT}, {96'b0, 32'h0000_3000});

        // redirect with a coincident ack discards the acked data
        step(0, 1, 4'd2, 1, 32'h0000_4000, 16'h0040);
        step(1, 0, 4'd0, 1, 32'h0000_5008, 16'h1234);
        chk("redir_ack_req", {127'b0, fetch_req}, 128'b1);
        chk("redir_ack_addr", {96'b0, fetch_addr}, {96'b0, 32'h0000_5000});
        chk("redir_ack_valid", {127'b0, ir_valid}, 128'b0);
        chk("redir_ack_cs", {112'b0, CS_OUT}, {112'b0, 16'h1234});
        step(1, 0, 4'd0, 0, 32'h0, 16'h0);
        wait_req(0);
        step(1, 0, 4'd0, 0, 32'h0, 16'h0);

        // random lengths across the 32-bit EIP wrap
        step(0, 0, 4'd0, 1, 32'hFFFF_FF84, 16'h0008);
        n_cons = 0;
        cyc = 0;
        while (n_cons < 100 && cyc < 3000) begin
            a = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 4) != 0);
            l = 4'($urandom_range(1, 15));
            if (q.size() >= 16 && r) n_cons++;
            step(a, r, l, 0, 32'h0, 16'h0);
            cyc++;
        end
        chk("rand_budget", {127'b0, n_cons >= 100}, 128'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
